// File: rtl/instr_field_split_if.sv
// Fetch/decode handshake bundle for instr_field_split.
// IR_JUMP_TARGET_EN adds the jump_target field.
interface instr_field_split_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] offset26;
  logic [31:0] pc_out;
  logic        is_rtype;
  logic        is_jump;
`ifdef IR_JUMP_TARGET_EN
  logic [31:0] jump_target;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, rd,
    input  shamt, funct, imm16, offset26, pc_out,
    input  is_rtype, is_jump, jump_target
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, opcode, rs, rt, rd,
    output shamt, funct, imm16, offset26, pc_out,
    output is_rtype, is_jump, jump_target
  );
`else
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, opcode, rs, rt, rd,
    input  shamt, funct, imm16, offset26, pc_out,
    input  is_rtype, is_jump
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, opcode, rs, rt, rd,
    output shamt, funct, imm16, offset26, pc_out,
    output is_rtype, is_jump
  );
`endif
endinterface

// File: rtl/instr_field_split.sv
// Fetch-to-decode FIFO that slices the head MIPS word into its fields.
// IR_JUMP_TARGET_EN adds jump_target formed from the head entry.
module instr_field_split #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  instr_field_split_if.slave  bus
);

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  logic [31:0]      r_instr [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W:0]   r_cnt;

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_head;
  logic [31:0] w_head_pc;

  assign w_in_ready  = (r_cnt != FULL);
  assign w_out_valid = (r_cnt != '0);
  assign w_push = bus.in_valid & w_in_ready & ~flush;
  assign w_pop  = w_out_valid & bus.out_ready & ~flush;

  // Power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc[i]    <= '0;
      end
    end else if (flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_instr[r_wr] <= bus.in_instr;
        r_pc[r_wr]    <= bus.in_pc;
        r_wr          <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign w_head    = r_instr[r_rd];
  assign w_head_pc = r_pc[r_rd];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.opcode    = w_head[31:26];
  assign bus.rs        = w_head[25:21];
  assign bus.rt        = w_head[20:16];
  assign bus.rd        = w_head[15:11];
  assign bus.shamt     = w_head[10:6];
  assign bus.funct     = w_head[5:0];
  assign bus.imm16     = w_head[15:0];
  assign bus.offset26  = w_head[25:0];
  assign bus.pc_out    = w_head_pc;
  assign bus.is_rtype  = (w_head[31:26] == 6'h00);
  assign bus.is_jump   = (w_head[31:26] == 6'h02) |
                         (w_head[31:26] == 6'h03);

`ifdef IR_JUMP_TARGET_EN
  assign bus.jump_target = {w_head_pc[31:28], w_head[25:0], 2'b00};
`endif

endmodule
